// File: rtl/ahb3lite_pkg.sv
// Shared AHB-Lite encodings and the memory slave state type.
// Used by ahb3lite_mem_slave; the AHB3LITE_SLV_WAIT_EN macro only affects the top module.
package ahb3lite_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [2:0] HSIZE_B8  = 3'b000;
    localparam logic [2:0] HSIZE_B16 = 3'b001;
    localparam logic [2:0] HSIZE_B32 = 3'b010;

    localparam logic [2:0] HBURST_SINGLE = 3'b000;
    localparam logic [2:0] HBURST_INCR   = 3'b001;
    localparam logic [2:0] HBURST_WRAP4  = 3'b010;
    localparam logic [2:0] HBURST_INCR4  = 3'b011;
    localparam logic [2:0] HBURST_WRAP8  = 3'b100;
    localparam logic [2:0] HBURST_INCR8  = 3'b101;
    localparam logic [2:0] HBURST_WRAP16 = 3'b110;
    localparam logic [2:0] HBURST_INCR16 = 3'b111;

    localparam logic [3:0] HPROT_OPCODE     = 4'b0000;
    localparam logic [3:0] HPROT_DATA       = 4'b0001;
    localparam logic [3:0] HPROT_PRIVILEGED = 4'b0010;
    localparam logic [3:0] HPROT_BUFFERABLE = 4'b0100;
    localparam logic [3:0] HPROT_CACHEABLE  = 4'b1000;

    localparam logic HWRITE_OP = 1'b1;
    localparam logic HREAD_OP  = 1'b0;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_WAIT = 3'd1,
        ST_DATA = 3'd2,
        ST_ERR1 = 3'd3,
        ST_ERR2 = 3'd4
    } ahb_slv_state_t;

    // Little-endian byte-lane enables for a transfer of the given size and low address bits.
    function automatic logic [3:0] lane_enables(input logic [2:0] hsize, input logic [1:0] addr);
        logic [3:0] be;
        case (hsize)
            HSIZE_B8:  be = 4'b0001 << addr;
            HSIZE_B16: be = 4'b0011 << {addr[1], 1'b0};
            HSIZE_B32: be = 4'b1111;
            default:   be = 4'b0000;
        endcase
        return be;
    endfunction

endpackage

// File: rtl/ahb3lite_mem_array.sv
// Byte-organised storage with a byte-enable word write port and an asynchronous word read port.
// Contents are deliberately not reset.
module ahb3lite_mem_array #(
    parameter int MEM_DEPTH = 256
) (
    input  logic                           clk,
    input  logic                           we,
    input  logic [3:0]                     be,
    input  logic [$clog2(MEM_DEPTH)-3:0]   addr,
    input  logic [31:0]                    wdata,
    output logic [31:0]                    rdata
);

    logic [7:0] mem_r [MEM_DEPTH];

    // Commit the enabled byte lanes of the addressed word.
    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (we && be[i]) begin
                mem_r[{addr, 2'(i)}] <= wdata[8*i +: 8];
            end
        end
    end

    assign rdata = {mem_r[{addr, 2'd3}], mem_r[{addr, 2'd2}],
                    mem_r[{addr, 2'd1}], mem_r[{addr, 2'd0}]};

endmodule

// File: rtl/ahb3lite_mem_slave.sv
// AHB-Lite byte-addressable memory slave with two-cycle ERROR responses.
// Define AHB3LITE_SLV_WAIT_EN to insert WAIT_STATES wait cycles before every legal data phase.
module ahb3lite_mem_slave
    import ahb3lite_pkg::*;
#(
    parameter int HADDR_SIZE  = 16,
    parameter int HDATA_SIZE  = 32,
    parameter int MEM_DEPTH   = 256,
    parameter int WAIT_STATES = 2
) (
    input  logic                  HCLK,
    input  logic                  HRESETn,
    input  logic                  HSEL,
    input  logic [HADDR_SIZE-1:0] HADDR,
    input  logic [HDATA_SIZE-1:0] HWDATA,
    output logic [HDATA_SIZE-1:0] HRDATA,
    input  logic                  HWRITE,
    input  logic [2:0]            HSIZE,
    input  logic [2:0]            HBURST,
    input  logic [3:0]            HPROT,
    input  logic [1:0]            HTRANS,
    input  logic                  HREADY,
    output logic                  HREADYOUT,
    output logic                  HRESP
);

    localparam int AW = $clog2(MEM_DEPTH);

    ahb_slv_state_t    state_r, state_nxt_s;
    logic [AW-3:0]     word_addr_r;
    logic              hwrite_r;
    logic [3:0]        be_r;
    logic              hreadyout_r, hresp_r;
    logic              accept_s, illegal_s, size_bad_s, misalign_s, range_bad_s;
    logic              we_s;
    logic [31:0]       mem_rdata_s, rd_mask_s;
    logic [HDATA_SIZE-1:0] hrdata_s;
    logic              unused_s;

`ifdef AHB3LITE_SLV_WAIT_EN
    localparam logic [3:0] WAIT_LOAD = 4'(WAIT_STATES);
    logic [3:0] wait_cnt_r, wait_cnt_nxt_s;
`endif

    assign unused_s = ^{HBURST, HPROT, HTRANS[0], 4'(WAIT_STATES)};

    // HREADYOUT gates acceptance too, so a held data phase never samples a new address.
    assign accept_s    = HSEL & HREADY & HTRANS[1] & hreadyout_r;
    assign range_bad_s = |HADDR[HADDR_SIZE-1:AW];

    // Classify the presented transfer's size and alignment.
    always_comb begin
        size_bad_s = 1'b0;
        misalign_s = 1'b0;
        case (HSIZE)
            HSIZE_B8:  misalign_s = 1'b0;
            HSIZE_B16: misalign_s = HADDR[0];
            HSIZE_B32: misalign_s = |HADDR[1:0];
            default:   size_bad_s = 1'b1;
        endcase
    end

    assign illegal_s = range_bad_s | size_bad_s | misalign_s;

    // Next-state decode; IDLE, DATA and ERR2 all end with HREADYOUT high and may take a new address.
    always_comb begin
        state_nxt_s = state_r;
`ifdef AHB3LITE_SLV_WAIT_EN
        wait_cnt_nxt_s = wait_cnt_r;
`endif
        case (state_r)
            ST_IDLE, ST_DATA, ST_ERR2: begin
                if (!accept_s) begin
                    state_nxt_s = ST_IDLE;
                end else if (illegal_s) begin
                    state_nxt_s = ST_ERR1;
                end else begin
`ifdef AHB3LITE_SLV_WAIT_EN
                    if (WAIT_LOAD != 4'd0) begin
                        state_nxt_s    = ST_WAIT;
                        wait_cnt_nxt_s = WAIT_LOAD - 4'd1;
                    end else begin
                        state_nxt_s = ST_DATA;
                    end
`else
                    state_nxt_s = ST_DATA;
`endif
                end
            end
`ifdef AHB3LITE_SLV_WAIT_EN
            ST_WAIT: begin
                if (wait_cnt_r == 4'd0) begin
                    state_nxt_s = ST_DATA;
                end else begin
                    wait_cnt_nxt_s = wait_cnt_r - 4'd1;
                end
            end
`endif
            ST_ERR1: state_nxt_s = ST_ERR2;
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // State, registered handshake outputs and address-phase capture.
    always_ff @(posedge HCLK) begin
        if (!HRESETn) begin
            state_r     <= ST_IDLE;
            hreadyout_r <= 1'b1;
            hresp_r     <= HRESP_OKAY;
            word_addr_r <= '0;
            hwrite_r    <= HREAD_OP;
            be_r        <= 4'b0000;
`ifdef AHB3LITE_SLV_WAIT_EN
            wait_cnt_r  <= 4'd0;
`endif
        end else begin
            state_r     <= state_nxt_s;
            hreadyout_r <= (state_nxt_s != ST_WAIT) && (state_nxt_s != ST_ERR1);
            hresp_r     <= (state_nxt_s == ST_ERR1) || (state_nxt_s == ST_ERR2);
`ifdef AHB3LITE_SLV_WAIT_EN
            wait_cnt_r  <= wait_cnt_nxt_s;
`endif
            if (accept_s) begin
                word_addr_r <= HADDR[AW-1:2];
                hwrite_r    <= HWRITE;
                be_r        <= lane_enables(HSIZE, HADDR[1:0]);
            end
        end
    end

    // Reset on the final edge cancels the write.
    assign we_s = (state_r == ST_DATA) && (hwrite_r == HWRITE_OP) && HRESETn;

    ahb3lite_mem_array #(
        .MEM_DEPTH (MEM_DEPTH)
    ) u_mem (
        .clk   (HCLK),
        .we    (we_s),
        .be    (be_r),
        .addr  (word_addr_r),
        .wdata (HWDATA[31:0]),
        .rdata (mem_rdata_s)
    );

    // Read data only on the active lanes of a completing read.
    always_comb begin
        rd_mask_s = {{8{be_r[3]}}, {8{be_r[2]}}, {8{be_r[1]}}, {8{be_r[0]}}};
        if ((state_r == ST_DATA) && (hwrite_r == HREAD_OP)) begin
            hrdata_s = mem_rdata_s & rd_mask_s;
        end else begin
            hrdata_s = {HDATA_SIZE{1'b0}};
        end
    end

    assign HRDATA    = hrdata_s;
    assign HREADYOUT = hreadyout_r;
    assign HRESP     = hresp_r;

endmodule

// File: tb/tb_ahb3lite_mem_slave.sv
// Directed bench for ahb3lite_mem_slave; expected wait count follows AHB3LITE_SLV_WAIT_EN.
module tb_ahb3lite_mem_slave;
    import ahb3lite_pkg::*;

    localparam int WS = 2;
`ifdef AHB3LITE_SLV_WAIT_EN
    localparam int EXP_WAITS = WS;
`else
    localparam int EXP_WAITS = 0;
`endif

    logic        hclk = 1'b0;
    logic        hresetn, hsel, hwrite;
    logic [15:0] haddr;
    logic [31:0] hwdata, hrdata;
    logic [2:0]  hsize, hburst;
    logic [3:0]  hprot;
    logic [1:0]  htrans;
    logic        hready, hreadyout, hresp;

    int n_checks = 0;
    int n_fail   = 0;
    int b_waits;
    int sum_waits;
    logic        b_first_ready, b_first_resp, b_resp;
    logic [31:0] b_rdata;

    assign hready = hreadyout;

    always #5 hclk = ~hclk;

    ahb3lite_mem_slave #(
        .HADDR_SIZE (16), .HDATA_SIZE (32), .MEM_DEPTH (256), .WAIT_STATES (WS)
    ) dut (
        .HCLK (hclk), .HRESETn (hresetn), .HSEL (hsel), .HADDR (haddr),
        .HWDATA (hwdata), .HRDATA (hrdata), .HWRITE (hwrite), .HSIZE (hsize),
        .HBURST (hburst), .HPROT (hprot), .HTRANS (htrans), .HREADY (hready),
        .HREADYOUT (hreadyout), .HRESP (hresp)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One bus cycle: present an address phase plus the write data of the previous one, held until HREADY.
    task automatic beat(input logic sel, input logic [1:0] trans, input logic wr,
                        input logic [15:0] addr, input logic [2:0] size, input logic [31:0] wdata);
        hsel = sel; htrans = trans; hwrite = wr; haddr = addr; hsize = size; hwdata = wdata;
        b_waits = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge hclk);
            if (i == 0) begin
                b_first_ready = hreadyout;
                b_first_resp  = hresp;
            end
            if (hreadyout === 1'b1) break;
            b_waits++;
        end
        if (hreadyout !== 1'b1) chk("beat_timeout", {31'd0, hreadyout}, 32'd1);
        b_rdata = hrdata;
        b_resp  = hresp;
        @(posedge hclk); #1;
    endtask

    task automatic write_xfer(input logic [15:0] addr, input logic [2:0] size, input logic [31:0] data);
        beat(1'b1, HTRANS_NONSEQ, HWRITE_OP, addr, size, 32'h0);
        beat(1'b0, HTRANS_IDLE, HREAD_OP, 16'h0, HSIZE_B8, data);
    endtask

    task automatic read_xfer(input logic [15:0] addr, input logic [2:0] size);
        beat(1'b1, HTRANS_NONSEQ, HREAD_OP, addr, size, 32'h0);
        beat(1'b0, HTRANS_IDLE, HREAD_OP, 16'h0, HSIZE_B8, 32'h0);
    endtask

    task automatic chk_error(input string tag);
        chk({tag, "_err1_ready"}, {31'd0, b_first_ready}, 32'd0);
        chk({tag, "_err1_resp"},  {31'd0, b_first_resp},  32'd1);
        chk({tag, "_err2_resp"},  {31'd0, b_resp},        32'd1);
        chk({tag, "_err_cycles"}, 32'(b_waits),           32'd1);
    endtask

    initial begin
        hresetn = 1'b0; hsel = 1'b0; hwrite = 1'b0; haddr = 16'h0; hwdata = 32'h0;
        hsize = HSIZE_B8; hburst = HBURST_INCR; hprot = HPROT_DATA; htrans = HTRANS_IDLE;
        repeat (3) @(posedge hclk);
        @(negedge hclk);
        chk("rst_hreadyout", {31'd0, hreadyout}, 32'd1);
        chk("rst_hresp",     {31'd0, hresp},     32'd0);
        chk("rst_hrdata",    hrdata,             32'h0);
        @(posedge hclk); #1;
        hresetn = 1'b1;

        write_xfer(16'h0000, HSIZE_B8, 32'h0000_0077);
        write_xfer(16'h0021, HSIZE_B8, 32'h0000_1100);

        // Byte write followed back-to-back by a read of the same byte.
        beat(1'b1, HTRANS_NONSEQ, HWRITE_OP, 16'h0020, HSIZE_B8, 32'h0);
        beat(1'b1, HTRANS_NONSEQ, HREAD_OP,  16'h0020, HSIZE_B8, 32'h0000_00DE);
        chk("bw_write_waits", 32'(b_waits), 32'(EXP_WAITS));
        chk("bw_write_resp",  {31'd0, b_resp}, 32'd0);
        beat(1'b0, HTRANS_IDLE, HREAD_OP, 16'h0, HSIZE_B8, 32'h0);
        chk("bw_read_data",  b_rdata, 32'h0000_00DE);
        chk("bw_read_resp",  {31'd0, b_resp}, 32'd0);
        chk("bw_read_waits", 32'(b_waits), 32'(EXP_WAITS));

        // Burst with a BUSY slot that must not write 0x21.
        beat(1'b1, HTRANS_NONSEQ, HWRITE_OP, 16'h0020, HSIZE_B8, 32'h0);
        beat(1'b1, HTRANS_BUSY,   HWRITE_OP, 16'h0021, HSIZE_B8, 32'h0000_00DE);
        beat(1'b1, HTRANS_SEQ,    HWRITE_OP, 16'h0022, HSIZE_B8, 32'h0000_AD00);
        chk("busy_ready",  {31'd0, b_first_ready}, 32'd1);
        chk("busy_waits",  32'(b_waits), 32'd0);
        beat(1'b1, HTRANS_SEQ,    HWRITE_OP, 16'h0023, HSIZE_B8, 32'h00BE_0000);
        beat(1'b0, HTRANS_IDLE,   HREAD_OP,  16'h0,    HSIZE_B8, 32'hEF00_0000);
        read_xfer(16'h0020, HSIZE_B32);
        chk("busy_readback", b_rdata, 32'hEFBE_11DE);
        read_xfer(16'h0021, HSIZE_B8);
        chk("busy_lane1", b_rdata, 32'h0000_1100);

        // IDLE cycles and deselected active transfers must not touch memory.
        write_xfer(16'h0030, HSIZE_B8, 32'h0000_0055);
        sum_waits = 0;
        for (int i = 0; i < 10; i++) begin
            beat(1'b1, HTRANS_IDLE, HWRITE_OP, 16'h0030, HSIZE_B8, 32'hFFFF_FFFF);
            sum_waits += b_waits;
        end
        for (int i = 0; i < 3; i++) begin
            beat(1'b0, HTRANS_NONSEQ, HWRITE_OP, 16'h0030, HSIZE_B8, 32'hFFFF_FFFF);
            sum_waits += b_waits;
        end
        beat(1'b0, HTRANS_IDLE, HREAD_OP, 16'h0, HSIZE_B8, 32'hFFFF_FFFF);
        sum_waits += b_waits;
        chk("idle_waits", 32'(sum_waits), 32'd0);
        read_xfer(16'h0030, HSIZE_B8);
        chk("idle_mem", b_rdata, 32'h0000_0055);

        // Illegal accesses: misaligned word, out of range, misaligned halfword, oversize.
        write_xfer(16'h0022, HSIZE_B32, 32'h1234_5678);
        chk_error("mis_word");
        write_xfer(16'h0100, HSIZE_B8, 32'h0000_00FF);
        chk_error("range");
        read_xfer(16'h0021, HSIZE_B16);
        chk_error("mis_half");
        read_xfer(16'h0020, 3'b011);
        chk_error("oversize");
        read_xfer(16'h0020, HSIZE_B32);
        chk("err_mem_0x20", b_rdata, 32'hEFBE_11DE);
        read_xfer(16'h0000, HSIZE_B8);
        chk("err_mem_0x00", b_rdata, 32'h0000_0077);

        write_xfer(16'h0022, HSIZE_B16, 32'hCAFE_0000);
        read_xfer(16'h0022, HSIZE_B16);
        chk("half_upper", b_rdata, 32'hCAFE_0000);

        // Word transfer with wait states.
        write_xfer(16'h0040, HSIZE_B32, 32'hDEAD_BEEF);
        chk("ws_write_waits", 32'(b_waits), 32'(EXP_WAITS));
        chk("ws_write_resp",  {31'd0, b_first_resp}, 32'd0);
        read_xfer(16'h0040, HSIZE_B32);
        chk("ws_read_waits", 32'(b_waits), 32'(EXP_WAITS));
        chk("ws_read_data",  b_rdata, 32'hDEAD_BEEF);

        // Reset in the middle of a write data phase.
        write_xfer(16'h0050, HSIZE_B32, 32'h0102_0304);
        beat(1'b1, HTRANS_NONSEQ, HWRITE_OP, 16'h0050, HSIZE_B32, 32'h0);
        hsel = 1'b0; htrans = HTRANS_IDLE; hwdata = 32'hFFFF_FFFF; hresetn = 1'b0;
        @(posedge hclk); #1;
        hresetn = 1'b1;
        @(negedge hclk);
        chk("rstmid_ready", {31'd0, hreadyout}, 32'd1);
        chk("rstmid_resp",  {31'd0, hresp},     32'd0);
        chk("rstmid_rdata", hrdata,             32'h0);
        @(posedge hclk); #1;
        read_xfer(16'h0050, HSIZE_B32);
        chk("rstmid_mem", b_rdata, 32'h0102_0304);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed no completion, expected end of test");
        $fatal(1, "watchdog expired");
    end

endmodule
